// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: slot-pair states, per-stage payload widths
// and packed control bundles that stages cast into a pipe_stage_buf.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic       pred_taken;
    } if_id_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic       dmem_ren;
        logic       dmem_wen;
        logic       halt;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [3:0] alu_op;
        logic [4:0] rd;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic       dmem_ren;
        logic       dmem_wen;
        logic       halt;
        logic       mem_to_reg;
        logic [2:0] funct3;
        logic [4:0] rd;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic       halt;
        logic       mem_to_reg;
        logic [4:0] rd;
    } mem_wb_ctrl_t;

    localparam int IF_ID_CTRL_W   = $bits(if_id_ctrl_t);
    localparam int IF_ID_DATA_W   = 64;
    localparam int ID_EX_CTRL_W   = $bits(id_ex_ctrl_t);
    localparam int ID_EX_DATA_W   = 160;
    localparam int EX_MEM_CTRL_W  = $bits(ex_mem_ctrl_t);
    localparam int EX_MEM_DATA_W  = 96;
    localparam int MEM_WB_CTRL_W  = $bits(mem_wb_ctrl_t);
    localparam int MEM_WB_DATA_W  = 64;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stream carrying a control word and a datapath word.
// The master drives the payload; the slave answers with ready.
interface pipe_stage_buf_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 160
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, ctrl, data, input ready);
    modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One pipeline entry {valid, ctrl, data}. Flush kills valid and ctrl;
// data only changes on a real load or a zeroing flush.
module pipe_slot #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 160
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              flush,
    input  logic              flush_zero,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ld_ctrl;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Clock-enabled data path: idle cycles leave these flops untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (flush && flush_zero) begin
            data <= '0;
        end else if (load && !flush) begin
            data <= ld_data;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready flow control, an
// optional skid entry for a registered in_ready, and flush-to-bubble.
module pipe_stage_buf
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W          = 160,
    parameter int CTRL_W          = 16,
    parameter int SKID            = 1,
    parameter int FLUSH_ZERO_DATA = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_stage_buf_if.slave     up,
    pipe_stage_buf_if.master    dn,
    output logic [1:0]          occupancy
);

    pipe_state_t       state_q;
    pipe_state_t       state_d;
    logic              accept;
    logic              issue;
    logic              flush_zero;

    logic              m_load;
    logic              m_clear;
    logic              m_from_skid;
    logic              s_load;
    logic              s_clear;

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    logic [CTRL_W-1:0] m_ld_ctrl;
    logic [DATA_W-1:0] m_ld_data;

    assign accept     = up.valid & up.ready;
    assign issue      = m_valid & dn.ready;
    assign flush_zero = (FLUSH_ZERO_DATA != 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= PS_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = PS_EMPTY;
        end else begin
            unique case (state_q)
                PS_EMPTY: if (accept) state_d = PS_FULL;
                PS_FULL: begin
                    if (accept && !issue)
                        state_d = (SKID != 0) ? PS_SKID : PS_FULL;
                    else if (!accept && issue)
                        state_d = PS_EMPTY;
                end
                PS_SKID:  if (issue) state_d = PS_FULL;
                default:  state_d = PS_EMPTY;
            endcase
        end
    end

    // Slot controls; flush priority is applied inside each slot
    always_comb begin
        m_load      = 1'b0;
        m_clear     = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clear     = 1'b0;
        unique case (state_q)
            PS_EMPTY: m_load = accept;
            PS_FULL: begin
                m_load  = accept & issue;
                s_load  = accept & ~issue;
                m_clear = issue & ~accept;
            end
            PS_SKID: begin
                m_load      = issue;
                m_from_skid = issue;
                s_clear     = issue;
            end
            default: ;
        endcase
    end

    assign m_ld_ctrl = m_from_skid ? s_ctrl : up.ctrl;
    assign m_ld_data = m_from_skid ? s_data : up.data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (m_load),
        .clear      (m_clear),
        .flush      (flush),
        .flush_zero (flush_zero),
        .ld_ctrl    (m_ld_ctrl),
        .ld_data    (m_ld_data),
        .valid      (m_valid),
        .ctrl       (m_ctrl),
        .data       (m_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk        (clk),
                .rst        (rst),
                .load       (s_load),
                .clear      (s_clear),
                .flush      (flush),
                .flush_zero (flush_zero),
                .ld_ctrl    (up.ctrl),
                .ld_data    (up.data),
                .valid      (s_valid),
                .ctrl       (s_ctrl),
                .data       (s_data)
            );
            assign up.ready = ~s_valid;
        end else begin : g_latch
            logic unused_skid;
            assign s_valid     = 1'b0;
            assign s_ctrl      = '0;
            assign s_data      = '0;
            assign unused_skid = ^{s_load, s_clear};
            assign up.ready    = ~m_valid | dn.ready;
        end
    endgenerate

    assign dn.valid  = m_valid;
    assign dn.ctrl   = m_valid ? m_ctrl : '0;
    assign dn.data   = m_data;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and random checks of pipe_stage_buf in skid and latch forms,
// with a scoreboard per instance tracking order, loss and occupancy.
module tb_pipe_stage_buf;

  localparam int CW = 8;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fa  = 1'b0;
  logic       fb  = 1'b0;
  logic       done = 1'b0;
  logic [1:0] occ_a;
  logic [1:0] occ_b;

  int tests = 0;
  int fails = 0;
  int seq   = 0;

  logic [CW+DW-1:0] qa[$];
  logic [CW+DW-1:0] qb[$];
  logic [CW+DW-1:0] ea;
  logic [CW+DW-1:0] eb;

  pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) a_up ();
  pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) a_dn ();
  pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) b_up ();
  pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) b_dn ();

  pipe_stage_buf #(
    .DATA_W(DW), .CTRL_W(CW),
    .SKID(1), .FLUSH_ZERO_DATA(1)
  ) dut_a (
    .clk(clk), .rst(rst), .flush(fa),
    .up(a_up), .dn(a_dn),
    .occupancy(occ_a)
  );

  pipe_stage_buf #(
    .DATA_W(DW), .CTRL_W(CW),
    .SKID(0), .FLUSH_ZERO_DATA(0)
  ) dut_b (
    .clk(clk), .rst(rst), .flush(fb),
    .up(b_up), .dn(b_dn),
    .occupancy(occ_b)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    if (!done) begin
      fails++;
      $error("FAIL timeout: bench did not finish");
      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
    end else begin
      chk("a_occ_sb", occ_a, qa.size());
      if (!a_dn.valid) chk("a_bubble", a_dn.ctrl, 0);
      if (a_dn.valid && a_dn.ready) begin
        ea = (qa.size() != 0) ? qa.pop_front() : 'x;
        chk("a_order", {a_dn.ctrl, a_dn.data}, ea);
      end
      if (fa) qa.delete();
      else if (a_up.valid && a_up.ready)
        qa.push_back({a_up.ctrl, a_up.data});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
    end else begin
      chk("b_occ_sb", occ_b, qb.size());
      if (!b_dn.valid) chk("b_bubble", b_dn.ctrl, 0);
      if (b_dn.valid && b_dn.ready) begin
        eb = (qb.size() != 0) ? qb.pop_front() : 'x;
        chk("b_order", {b_dn.ctrl, b_dn.data}, eb);
      end
      if (fb) qb.delete();
      else if (b_up.valid && b_up.ready)
        qb.push_back({b_up.ctrl, b_up.data});
    end
  end

  initial begin
    a_up.valid = 1'b0; a_up.ctrl = '0;
    a_up.data = '0; a_dn.ready = 1'b0;
    b_up.valid = 1'b0; b_up.ctrl = '0;
    b_up.data = '0; b_dn.ready = 1'b0;

    tick();
    chk("rst_a_valid", a_dn.valid, 0);
    chk("rst_a_ctrl", a_dn.ctrl, 0);
    chk("rst_a_data", a_dn.data, 0);
    chk("rst_a_occ", occ_a, 0);
    chk("rst_b_valid", b_dn.valid, 0);
    chk("rst_b_occ", occ_b, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_a_in_ready", a_up.ready, 1);
    chk("rst_b_in_ready", b_up.ready, 1);

    a_dn.ready = 1'b1;
    b_dn.ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      a_up.valid = 1'b1;
      a_up.data = DW'(i);
      a_up.ctrl = CW'(i);
      b_up.valid = 1'b1;
      b_up.data = DW'(i + 100);
      b_up.ctrl = CW'(i);
      tick();
      chk("stream_a_data", a_dn.data, i);
      chk("stream_a_valid", a_dn.valid, 1);
      chk("stream_a_occ", occ_a, 1);
      chk("stream_b_data", b_dn.data, i + 100);
      chk("stream_b_occ", occ_b, 1);
    end
    a_up.valid = 1'b0;
    b_up.valid = 1'b0;
    tick();
    chk("stream_a_drain", a_dn.valid, 0);
    chk("stream_b_drain", b_dn.valid, 0);

    a_dn.ready = 1'b0;
    a_up.valid = 1'b1;
    a_up.ctrl = 8'h0a; a_up.data = 32'ha;
    tick();
    chk("bp_occ1", occ_a, 1);
    a_up.ctrl = 8'h0b; a_up.data = 32'hb;
    tick();
    chk("bp_occ2", occ_a, 2);
    chk("bp_in_ready0", a_up.ready, 0);
    chk("bp_data_a", a_dn.data, 32'ha);
    a_up.ctrl = 8'h0c; a_up.data = 32'hc;
    tick();
    chk("bp_hold_data", a_dn.data, 32'ha);
    chk("bp_hold_ctrl", a_dn.ctrl, 8'h0a);
    chk("bp_hold_occ", occ_a, 2);
    a_up.valid = 1'b0;
    a_dn.ready = 1'b1;
    tick();
    chk("bp_next_b", a_dn.data, 32'hb);
    chk("bp_occ_after", occ_a, 1);
    chk("bp_in_ready1", a_up.ready, 1);
    tick();
    chk("bp_empty", a_dn.valid, 0);

    a_dn.ready = 1'b0;
    a_up.valid = 1'b1;
    a_up.ctrl = 8'ha1; a_up.data = 32'ha1;
    tick();
    a_up.ctrl = 8'hb1; a_up.data = 32'hb1;
    tick();
    chk("fl_a_occ2", occ_a, 2);
    a_up.ctrl = 8'hc1; a_up.data = 32'hc1;
    fa = 1'b1;
    tick();
    fa = 1'b0;
    a_up.valid = 1'b0;
    chk("fl_a_valid", a_dn.valid, 0);
    chk("fl_a_ctrl", a_dn.ctrl, 0);
    chk("fl_a_occ", occ_a, 0);
    chk("fl_a_data_zero", a_dn.data, 0);

    a_up.valid = 1'b1;
    a_up.ctrl = 8'hd0; a_up.data = 32'hd0;
    tick();
    a_up.ctrl = 8'he0; a_up.data = 32'he0;
    fa = 1'b1;
    #1;
    chk("fl_a_accept_open", a_up.ready, 1);
    tick();
    fa = 1'b0;
    a_up.valid = 1'b0;
    chk("fl_a_drop_occ", occ_a, 0);
    chk("fl_a_drop_data", a_dn.data, 0);
    a_dn.ready = 1'b1;
    tick();
    chk("fl_a_never_e0", a_dn.valid, 0);

    b_dn.ready = 1'b0;
    b_up.valid = 1'b1;
    b_up.ctrl = 8'h55; b_up.data = 32'h55;
    tick();
    b_up.ctrl = 8'h66; b_up.data = 32'h66;
    fb = 1'b1;
    tick();
    fb = 1'b0;
    b_up.valid = 1'b0;
    chk("fl_b_valid", b_dn.valid, 0);
    chk("fl_b_ctrl", b_dn.ctrl, 0);
    chk("fl_b_occ", occ_b, 0);
    chk("fl_b_data_kept", b_dn.data, 32'h55);

    b_up.valid = 1'b1;
    b_up.ctrl = 8'h11; b_up.data = 32'h11;
    tick();
    chk("st_b_data_a", b_dn.data, 32'h11);
    b_up.ctrl = 8'h22; b_up.data = 32'h22;
    #1;
    chk("st_b_ready0", b_up.ready, 0);
    tick();
    chk("st_b_hold", b_dn.data, 32'h11);
    b_dn.ready = 1'b1;
    #1;
    chk("st_b_ready1", b_up.ready, 1);
    tick();
    chk("st_b_data_b", b_dn.data, 32'h22);
    chk("st_b_occ", occ_b, 1);
    b_up.valid = 1'b0;
    tick();
    chk("st_b_empty", b_dn.valid, 0);

    a_up.valid = 1'b0; a_up.ctrl = '1;
    a_up.data = DW'($urandom);
    b_up.valid = 1'b0; b_up.ctrl = '1;
    b_up.data = DW'($urandom);
    tick();
    chk("bub_a_ctrl", a_dn.ctrl, 0);
    chk("bub_b_ctrl", b_dn.ctrl, 0);
    tick();
    chk("bub_a_valid", a_dn.valid, 0);

    a_dn.ready = 1'b0;
    a_up.valid = 1'b1;
    a_up.ctrl = 8'h77; a_up.data = 32'h77;
    tick();
    a_up.ctrl = 8'h88; a_up.data = 32'h88;
    tick();
    chk("mr_occ2", occ_a, 2);
    rst = 1'b1;
    #1;
    chk("mr_valid", a_dn.valid, 0);
    chk("mr_ctrl", a_dn.ctrl, 0);
    chk("mr_data", a_dn.data, 0);
    chk("mr_occ", occ_a, 0);
    a_up.valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mr_in_ready", a_up.ready, 1);
    chk("mr_occ_after", occ_a, 0);

    for (int c = 0; c < 4000; c++) begin
      seq++;
      a_up.valid = 1'($urandom_range(0, 1));
      a_up.ctrl  = CW'($urandom);
      a_up.data  = DW'(seq);
      a_dn.ready = ($urandom_range(0, 9) < 6);
      fa         = ($urandom_range(0, 63) == 0);
      b_up.valid = 1'($urandom_range(0, 1));
      b_up.ctrl  = CW'($urandom);
      b_up.data  = DW'(seq + 32'h1000_0000);
      b_dn.ready = ($urandom_range(0, 9) < 6);
      fb         = ($urandom_range(0, 63) == 0);
      tick();
    end
    a_up.valid = 1'b0; a_dn.ready = 1'b1; fa = 1'b0;
    b_up.valid = 1'b0; b_dn.ready = 1'b1; fb = 1'b0;
    repeat (4) tick();
    chk("rand_a_drained", qa.size(), 0);
    chk("rand_b_drained", qb.size(), 0);
    chk("rand_a_occ", occ_a, 0);
    chk("rand_b_occ", occ_b, 0);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
